// File: rtl/counter_mod_updown_if.sv
// counter_mod_updown_if
//   Control/status bundle for counter_mod_updown.
//   master : drives clear, load, load_val, en, up; observes the count and flags.
//   slave  : the counter itself.
//   Signals:
//     clear     sync clear of count and prescaler
//     load      sync parallel load
//     load_val  value to load (clamped to MODULO-1 by the counter)
//     en        count enable (feeds the prescaler)
//     up        1 = count up, 0 = count down
//     P         registered count
//     at_max    P == MODULO-1
//     at_zero   P == 0
//     tc        this cycle's step crosses the range end (cascade enable)
//     wrap      one-cycle pulse the cycle after a wrap
interface counter_mod_updown_if #(
  parameter int WIDTH = 8
) ();

  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] P;
  logic             at_max;
  logic             at_zero;
  logic             tc;
  logic             wrap;

  modport master (
    output clear, load, load_val, en, up,
    input  P, at_max, at_zero, tc, wrap
  );

  modport slave (
    input  clear, load, load_val, en, up,
    output P, at_max, at_zero, tc, wrap
  );

endinterface

// File: rtl/counter_mod_updown.sv
// counter_mod_updown
//   Modulo up/down counter with parallel load, synchronous clear, prescaled
//   enable and wrap/saturate mode. Used as a general event/timebase counter.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high reset
//     bus    counter_mod_updown_if.slave (controls in, count and flags out)
//   Parameters:
//     WIDTH     count width
//     MODULO    count range 0..MODULO-1 (2..2**WIDTH)
//     SATURATE  0 = wrap at range ends, 1 = hold at range ends
//     PRESCALE  count advances once every PRESCALE enabled cycles (>= 1)
//   The interface WIDTH parameter must match the counter WIDTH.
module counter_mod_updown #(
  parameter int WIDTH    = 8,
  parameter int MODULO   = 2**WIDTH,
  parameter bit SATURATE = 1'b0,
  parameter int PRESCALE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  counter_mod_updown_if.slave  bus
);

  localparam int               PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] MAX      = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] p_q;
  logic [PSC_W-1:0] psc_q;
  logic             wrap_q;

  logic             step;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] p_step;
  logic             wrap_step;

  assign at_max  = (p_q == MAX);
  assign at_zero = (p_q == '0);
  assign step    = bus.en & (psc_q == PSC_LAST);

  // Next count for a step. Range ends are tested before any +/-1, so no
  // intermediate value ever leaves WIDTH bits.
  always_comb begin
    p_step    = p_q;
    wrap_step = 1'b0;
    if (bus.up) begin
      if (at_max) begin
        if (!SATURATE) begin
          p_step    = '0;
          wrap_step = 1'b1;
        end
      end else begin
        p_step = p_q + WIDTH'(1);
      end
    end else begin
      if (at_zero) begin
        if (!SATURATE) begin
          p_step    = MAX;
          wrap_step = 1'b1;
        end
      end else begin
        p_step = p_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q    <= '0;
      psc_q  <= '0;
      wrap_q <= 1'b0;
    end else if (bus.clear) begin
      p_q    <= '0;
      psc_q  <= '0;
      wrap_q <= 1'b0;
    end else if (bus.load) begin
      // load_val > MAX is the same as load_val >= MODULO, without needing
      // a constant wider than WIDTH.
      p_q    <= (bus.load_val > MAX) ? MAX : bus.load_val;
      psc_q  <= '0;
      wrap_q <= 1'b0;
    end else if (bus.en) begin
      if (step) begin
        p_q    <= p_step;
        psc_q  <= '0;
        wrap_q <= wrap_step;
      end else begin
        psc_q  <= psc_q + PSC_W'(1);
        wrap_q <= 1'b0;
      end
    end else begin
      wrap_q <= 1'b0;
    end
  end

  // tc ignores SATURATE so a cascade sees the same enable in either mode.
  assign bus.P       = p_q;
  assign bus.at_max  = at_max;
  assign bus.at_zero = at_zero;
  assign bus.tc      = step & ((bus.up & at_max) | (~bus.up & at_zero));
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_counter_mod_updown.sv
module tb_counter_mod_updown;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  counter_mod_updown_if #(.WIDTH(4)) bus_a  ();
  counter_mod_updown_if #(.WIDTH(4)) bus_s  ();
  counter_mod_updown_if #(.WIDTH(4)) bus_p  ();
  counter_mod_updown_if #(.WIDTH(4)) bus_lo ();
  counter_mod_updown_if #(.WIDTH(4)) bus_hi ();

  counter_mod_updown #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0), .PRESCALE(1))
    u_a  (.clk(clk), .reset(reset), .bus(bus_a.slave));
  counter_mod_updown #(.WIDTH(4), .MODULO(10), .SATURATE(1'b1), .PRESCALE(1))
    u_s  (.clk(clk), .reset(reset), .bus(bus_s.slave));
  counter_mod_updown #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0), .PRESCALE(3))
    u_p  (.clk(clk), .reset(reset), .bus(bus_p.slave));
  counter_mod_updown #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0), .PRESCALE(1))
    u_lo (.clk(clk), .reset(reset), .bus(bus_lo.slave));
  counter_mod_updown #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0), .PRESCALE(1))
    u_hi (.clk(clk), .reset(reset), .bus(bus_hi.slave));

  // low stage terminal count enables the high stage
  assign bus_hi.en = bus_lo.tc;

  localparam int A_P = 0, A_MAX = 1, A_ZERO = 2, A_TC = 3, A_WRAP = 4;
  localparam int S_P = 5, S_TC = 6, S_WRAP = 7;
  localparam int P_P = 8, P_WRAP = 9, P_ZERO = 10;
  localparam int LO_P = 11, HI_P = 12, HI_WRAP = 13, HI_WCNT = 14;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   hi_wrap_cnt = 0;

  function automatic logic [31:0] actual(int sig);
    case (sig)
      A_P:     return 32'(bus_a.P);
      A_MAX:   return 32'(bus_a.at_max);
      A_ZERO:  return 32'(bus_a.at_zero);
      A_TC:    return 32'(bus_a.tc);
      A_WRAP:  return 32'(bus_a.wrap);
      S_P:     return 32'(bus_s.P);
      S_TC:    return 32'(bus_s.tc);
      S_WRAP:  return 32'(bus_s.wrap);
      P_P:     return 32'(bus_p.P);
      P_WRAP:  return 32'(bus_p.wrap);
      P_ZERO:  return 32'(bus_p.at_zero);
      LO_P:    return 32'(bus_lo.P);
      HI_P:    return 32'(bus_hi.P);
      HI_WRAP: return 32'(bus_hi.wrap);
      HI_WCNT: return 32'(hi_wrap_cnt);
      default: return 32'hdead_beef;
    endcase
  endfunction

  // monitor: drain every expectation queued for this cycle
  always @(negedge clk) begin
    chk_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      tests++;
      if (actual(e.sig) !== e.exp) begin
        fails++;
        $display("FAIL %s: got %0d expected %0d at %0t", e.name, actual(e.sig), e.exp, $time);
      end
    end
  end

  always @(negedge clk) begin
    if (bus_hi.wrap === 1'b1) hi_wrap_cnt++;
  end

  task automatic chk(input string name, input int sig, input logic [31:0] exp);
    q.push_back('{name, sig, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int en_seq [12] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
  int p_seq  [12] = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3, 3};

  initial begin
    bus_a.clear  = 0; bus_a.load  = 0; bus_a.load_val  = 0; bus_a.en  = 0; bus_a.up  = 1;
    bus_s.clear  = 0; bus_s.load  = 0; bus_s.load_val  = 0; bus_s.en  = 0; bus_s.up  = 1;
    bus_p.clear  = 0; bus_p.load  = 0; bus_p.load_val  = 0; bus_p.en  = 0; bus_p.up  = 1;
    bus_lo.clear = 0; bus_lo.load = 0; bus_lo.load_val = 0; bus_lo.en = 0; bus_lo.up = 1;
    bus_hi.clear = 0; bus_hi.load = 0; bus_hi.load_val = 0; bus_hi.up = 1;

    #1;
    chk("rst_p", A_P, 0);
    chk("rst_at_zero", A_ZERO, 1);
    chk("rst_at_max", A_MAX, 0);
    chk("rst_tc", A_TC, 0);
    chk("rst_wrap", A_WRAP, 0);
    @(negedge clk);
    #1;
    tick();
    reset = 0;

    // modulo-10 up count from reset
    bus_a.en = 1; bus_a.up = 1;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("up_p_%0d", k), A_P, 32'(k % 10));
      chk($sformatf("up_tc_%0d", k), A_TC, 32'((k % 10) == 9));
      chk($sformatf("up_wrap_%0d", k), A_WRAP, 32'(k == 10));
      tick();
    end

    // clear beats a simultaneous enable
    bus_a.clear = 1;
    tick();
    chk("clr_en_p", A_P, 0);
    chk("clr_en_wrap", A_WRAP, 0);
    bus_a.clear = 0; bus_a.up = 0;
    chk("dn_tc_at0", A_TC, 1);
    chk("dn_at_zero", A_ZERO, 1);
    tick();
    chk("dn_p_9", A_P, 9);
    chk("dn_wrap", A_WRAP, 1);
    chk("dn_tc_at9", A_TC, 0);
    chk("dn_at_max", A_MAX, 1);
    tick();
    chk("dn_p_8", A_P, 8);
    chk("dn_wrap_off", A_WRAP, 0);
    bus_a.en = 0;
    tick();
    chk("hold_p_8", A_P, 8);

    // load clamps and suppresses the step
    bus_a.en = 1; bus_a.up = 1; bus_a.load = 1; bus_a.load_val = 12;
    tick();
    chk("load12_p", A_P, 9);
    chk("load12_at_max", A_MAX, 1);
    chk("load12_wrap", A_WRAP, 0);
    bus_a.load = 0;
    chk("load12_tc", A_TC, 1);
    bus_a.load = 1; bus_a.load_val = 3;
    tick();
    chk("load3_no_inc", A_P, 3);
    bus_a.clear = 1; bus_a.load_val = 5;
    tick();
    chk("clr_over_load", A_P, 0);
    bus_a.clear = 0; bus_a.load = 0; bus_a.en = 0;

    // saturating instance
    bus_s.en = 1; bus_s.up = 0;
    chk("sat_dn_tc", S_TC, 1);
    tick();
    chk("sat_dn_p", S_P, 0);
    chk("sat_dn_wrap", S_WRAP, 0);
    chk("sat_dn_tc2", S_TC, 1);
    tick();
    chk("sat_dn_p2", S_P, 0);
    chk("sat_dn_wrap2", S_WRAP, 0);
    bus_s.load = 1; bus_s.load_val = 15; bus_s.up = 1;
    tick();
    chk("sat_load15", S_P, 9);
    bus_s.load = 0;
    chk("sat_up_tc", S_TC, 1);
    tick();
    chk("sat_up_p", S_P, 9);
    chk("sat_up_wrap", S_WRAP, 0);
    bus_s.en = 0;

    // prescale 3 with an enable gap
    bus_p.up = 1;
    for (int i = 0; i < 12; i++) begin
      bus_p.en = en_seq[i];
      tick();
      chk($sformatf("psc_p_%0d", i), P_P, 32'(p_seq[i]));
    end

    // async reset mid-prescale at P=7, psc=1
    bus_p.en = 1; bus_p.load = 1; bus_p.load_val = 7;
    tick();
    bus_p.load = 0;
    chk("psc_load7", P_P, 7);
    tick();
    #1;
    reset = 1;
    #1;
    chk("arst_p", P_P, 0);
    chk("arst_wrap", P_WRAP, 0);
    chk("arst_at_zero", P_ZERO, 1);
    @(negedge clk);
    #1;
    reset = 0;
    tick();
    chk("arst_e1", P_P, 0);
    tick();
    chk("arst_e2", P_P, 0);
    tick();
    chk("arst_e3", P_P, 1);
    bus_p.en = 0;

    // two-stage decade cascade
    bus_lo.en = 1;
    for (int i = 0; i < 57; i++) tick();
    chk("casc57_lo", LO_P, 7);
    chk("casc57_hi", HI_P, 5);
    for (int i = 57; i < 100; i++) tick();
    chk("casc100_lo", LO_P, 0);
    chk("casc100_hi", HI_P, 0);
    chk("casc100_hi_wrap", HI_WRAP, 1);
    bus_lo.en = 0;
    tick();
    chk("casc_hi_wrap_once", HI_WCNT, 1);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      $display("FAIL drain: got %0d pending expected 0", q.size());
      fails += q.size();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/counter_mod_updown.md
Name: counter_mod_updown

Overview:
- Parametrised successor to the team's fixed 4-bit free-running counter.
- Configurable width, modulo, up/down direction, parallel load, synchronous clear, enable with prescaler, and wrap or saturate mode.
- Provides terminal-count and wrap flags for cascading.
- Used as the general-purpose event/timebase counter in lab datapaths, e.g. display refresh, digit scan and BCD stages.

Parameters:
- WIDTH, 8: bit width of count output P.
- MODULO, 2**WIDTH: count range 0..MODULO-1; legal range 2 <= MODULO <= 2**WIDTH.
- SATURATE, 0: 0 = wrap at the range ends; 1 = hold at the range ends.
- PRESCALE, 1: P steps once every PRESCALE enabled cycles; legal range >= 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous clear of count and prescaler.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value to load.
- en  input  1  count enable.
- up  input  1  1 = count up, 0 = count down.
- P  output  WIDTH  current count, registered.
- at_max  output  1  P == MODULO-1, combinational from P.
- at_zero  output  1  P == 0, combinational from P.
- tc  output  1  terminal count, combinational; high when this cycle's step crosses the range end.
- wrap  output  1  registered one-cycle pulse, high the cycle after a wrap occurred.

Behaviour:
- Reset (async, any time, including mid-prescale):
  - P=0, prescaler=0, wrap=0.
  - Resulting flags: at_zero=1, at_max=0 (MODULO>=2), tc=0 unless en=1 and step conditions hold.
- Priority per rising edge: clear > load > en step. up is sampled only on a step.
- clear=1:
  - P<=0, prescaler<=0, wrap<=0.
  - Overrides a simultaneous load/en.
- load=1 (clear=0):
  - P<=load_val, clamped to MODULO-1 when load_val >= MODULO.
  - prescaler<=0, wrap<=0. No step this cycle, even with en=1.
- Prescaler: internal counter psc, 0..PRESCALE-1, advances only when en=1 and no clear/load.
  - step = en & (psc == PRESCALE-1).
  - psc wraps to 0 on step.
  - PRESCALE=1 means every enabled cycle is a step and psc is constant 0.
- en=0: P and psc hold; wrap<=0.
- Step up:
  - P < MODULO-1: P<=P+1.
  - P == MODULO-1, SATURATE=0: P<=0 and wrap<=1.
  - P == MODULO-1, SATURATE=1: P holds and wrap stays 0.
- Step down:
  - P > 0: P<=P-1.
  - P == 0, SATURATE=0: P<=MODULO-1 and wrap<=1.
  - P == 0, SATURATE=1: P holds.
- tc = step & ((up & at_max) | (~up & at_zero)), independent of SATURATE.
  - Intended to drive the next stage's en, so a cascade advances in the same edge as the wrap.
- Arithmetic: all in WIDTH bits; no intermediate overflow. With MODULO = 2**WIDTH, the natural wrap equals the modulo wrap.
- Direction change mid-count: takes effect on the next step with no extra latency; prescaler progress is kept.
- Latency: P updates 1 clk after a qualifying edge; wrap lags the wrapping edge by 1 clk; tc and the at_* flags have zero latency.

Test Plan:
- WIDTH=4, MODULO=10, PRESCALE=1, SATURATE=0, up=1, en=1 from reset:
  - P runs 0..9, 0, 1.
  - tc high only in the cycle where P==9.
  - wrap high exactly 1 clk after P goes 9->0.
- Same config, up=0, starting from P=0:
  - P goes 0->9->8.
  - tc high while P==0; wrap pulses once.
  - SATURATE=1 variant: P stays 0, wrap never asserts, tc still high while P==0.
- PRESCALE=3, en=1 continuously:
  - P increments every 3rd clk.
  - Deassert en for 2 clks mid-prescale: P and psc freeze, then resume with no lost or extra count.
- load_val=12 with MODULO=10: P=9, at_max=1.
  - load together with en in the same cycle: no increment in that cycle.
  - clear together with load_val=5: P=0.
- Assert reset asynchronously between clock edges while P=7, psc=1: P=0 and wrap=0 before the next edge; counting restarts from psc=0 after release.
- Cascade two instances (MODULO=10), low tc -> high en: from a reset start, after 100 enabled clks the pair reads high=0, low=0 with the high wrap pulse seen once; at 57 clks it reads 5/7.
